alu_issue_stage: RTL and testbench

ID/EX issue stage that drives the execute-stage ALU. It decodes a MIPS instruction in ID into the ALU control code, operands and shift amount. It registers those values together with writeback and memory controls into the ID/EX pipeline register. It supports stall (hold) and flush (bubble) from the hazard unit. Latency is 1 cycle from ID to EX.

---
 rtl/alu_pkg.sv | 69 ++++++
 rtl/alu_issue_decode.sv | 82 ++++++++
 rtl/alu_issue_stage.sv | 133 +++++++++++++
 tb/tb_alu_issue_stage.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU/decode definitions: ALU op codes, MIPS opcode/funct constants,
// decoded-control record and the bubble defaults used by the issue stage.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_SLL = 4'b0000,
    ALU_ADD = 4'b0001,
    ALU_SUB = 4'b0010,
    ALU_AND = 4'b0100,
    ALU_OR  = 4'b0101,
    ALU_XOR = 4'b0110,
    ALU_LUI = 4'b0111,
    ALU_SLT = 4'b1010,
    ALU_SRL = 4'b1111
  } alu_op_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [1:0] {
    IMM_NONE = 2'd0,
    IMM_SEXT = 2'd1,
    IMM_ZEXT = 2'd2
  } imm_mode_e;

  typedef struct packed {
    alu_op_e   alu_op;
    logic [4:0] shamt;
    logic [4:0] dest;
    imm_mode_e imm_mode;
    logic      zero_data1;
    logic      reg_write;
    logic      mem_read;
    logic      mem_write;
    logic      branch;
    logic      illegal;
  } dec_t;

  localparam alu_op_e BUBBLE_ALU_OP = ALU_ADD;

  function automatic dec_t dec_bubble();
    dec_t d;
    d          = '0;
    d.alu_op   = BUBBLE_ALU_OP;
    d.imm_mode = IMM_NONE;
    return d;
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational MIPS decode: instruction word -> ALU op, destination,
// immediate handling and memory/branch controls.
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       unused_rs;

  assign op        = instr[31:26];
  assign funct     = instr[5:0];
  assign rt        = instr[20:16];
  assign rd        = instr[15:11];
  assign unused_rs = ^instr[25:21];

  always_comb begin
    dec      = dec_bubble();
    dec.dest = (op == OP_RTYPE) ? rd : rt;
    case (op)
      OP_RTYPE: begin
        dec.reg_write = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: dec.alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: dec.alu_op = ALU_SUB;
          FN_AND:          dec.alu_op = ALU_AND;
          FN_OR:           dec.alu_op = ALU_OR;
          FN_XOR:          dec.alu_op = ALU_XOR;
          FN_SLT:          dec.alu_op = ALU_SLT;
          FN_SLL, FN_SRL: begin
            dec.alu_op     = (funct == FN_SLL) ? ALU_SLL : ALU_SRL;
            dec.shamt      = instr[10:6];
            dec.zero_data1 = 1'b1;
          end
          default:         dec.illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        dec.alu_op = ALU_ADD; dec.imm_mode = IMM_SEXT; dec.reg_write = 1'b1;
      end
      OP_SLTI: begin
        dec.alu_op = ALU_SLT; dec.imm_mode = IMM_SEXT; dec.reg_write = 1'b1;
      end
      OP_ANDI: begin
        dec.alu_op = ALU_AND; dec.imm_mode = IMM_ZEXT; dec.reg_write = 1'b1;
      end
      OP_ORI: begin
        dec.alu_op = ALU_OR;  dec.imm_mode = IMM_ZEXT; dec.reg_write = 1'b1;
      end
      OP_XORI: begin
        dec.alu_op = ALU_XOR; dec.imm_mode = IMM_ZEXT; dec.reg_write = 1'b1;
      end
      OP_LUI: begin
        dec.alu_op = ALU_LUI; dec.imm_mode = IMM_ZEXT; dec.reg_write = 1'b1;
        dec.zero_data1 = 1'b1;
      end
      OP_LW: begin
        dec.alu_op = ALU_ADD; dec.imm_mode = IMM_SEXT; dec.reg_write = 1'b1;
        dec.mem_read = 1'b1;
      end
      OP_SW: begin
        dec.alu_op = ALU_ADD; dec.imm_mode = IMM_SEXT; dec.mem_write = 1'b1;
      end
      OP_BEQ: begin
        dec.alu_op = ALU_SUB; dec.branch = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    // An illegal instruction travels as a bubble that only carries the flag
    if (dec.illegal) begin
      dec         = dec_bubble();
      dec.illegal = 1'b1;
    end
    if (dec.dest == '0) dec.reg_write = 1'b0;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decode, optional writeback bypass and the ID/EX register.
// Optional writeback bypass ports are enabled by ALU_ISSUE_WB_BYPASS_EN.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [31:0]   id_instr,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic          stall,
  input  logic          flush,
`ifdef ALU_ISSUE_WB_BYPASS_EN
  input  logic          wb_we,
  input  logic [RW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
`endif
  output logic          ex_valid,
  output logic [3:0]    ex_alu_ctrl,
  output logic [DW-1:0] ex_data1,
  output logic [DW-1:0] ex_data2,
  output logic [4:0]    ex_shamt,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_dest,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_branch,
  output logic          ex_illegal
);

  typedef struct packed {
    logic          valid;
    logic [3:0]    alu_ctrl;
    logic [DW-1:0] data1;
    logic [DW-1:0] data2;
    logic [4:0]    shamt;
    logic [DW-1:0] store_data;
    logic [RW-1:0] dest;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          branch;
    logic          illegal;
  } ex_t;

  function automatic ex_t ex_bubble();
    ex_t b;
    b          = '0;
    b.alu_ctrl = BUBBLE_ALU_OP;
    return b;
  endfunction

  dec_t          dec;
  logic [DW-1:0] rs_val;
  logic [DW-1:0] rt_val;
  logic [DW-1:0] op2;
  ex_t           ex_load;
  ex_t           ex_d;
  ex_t           ex_q;

  alu_issue_decode u_decode (
    .instr (id_instr),
    .dec   (dec)
  );

`ifdef ALU_ISSUE_WB_BYPASS_EN
  assign rs_val = (wb_we && (wb_addr != '0) && (wb_addr == RW'(id_instr[25:21])))
                  ? wb_data : id_rs_data;
  assign rt_val = (wb_we && (wb_addr != '0) && (wb_addr == RW'(id_instr[20:16])))
                  ? wb_data : id_rt_data;
`else
  assign rs_val = id_rs_data;
  assign rt_val = id_rt_data;
`endif

  always_comb begin
    case (dec.imm_mode)
      IMM_SEXT: op2 = {{(DW-16){id_instr[15]}}, id_instr[15:0]};
      IMM_ZEXT: op2 = {{(DW-16){1'b0}}, id_instr[15:0]};
      default:  op2 = rt_val;
    endcase
  end

  always_comb begin
    ex_load            = ex_bubble();
    ex_load.valid      = 1'b1;
    ex_load.alu_ctrl   = dec.alu_op;
    ex_load.shamt      = dec.shamt;
    ex_load.dest       = RW'(dec.dest);
    ex_load.reg_write  = dec.reg_write;
    ex_load.mem_read   = dec.mem_read;
    ex_load.mem_write  = dec.mem_write;
    ex_load.branch     = dec.branch;
    ex_load.illegal    = dec.illegal;
    if (!dec.illegal) begin
      ex_load.data1      = dec.zero_data1 ? '0 : rs_val;
      ex_load.data2      = op2;
      ex_load.store_data = rt_val;
    end
  end

  always_comb begin
    ex_d = ex_q;
    if (flush)         ex_d = ex_bubble();
    else if (stall)    ex_d = ex_q;
    else if (id_valid) ex_d = ex_load;
    else               ex_d = ex_bubble();
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= ex_bubble();
    else        ex_q <= ex_d;
  end

  assign ex_valid      = ex_q.valid;
  assign ex_alu_ctrl   = ex_q.alu_ctrl;
  assign ex_data1      = ex_q.data1;
  assign ex_data2      = ex_q.data2;
  assign ex_shamt      = ex_q.shamt;
  assign ex_store_data = ex_q.store_data;
  assign ex_dest       = ex_q.dest;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_branch     = ex_q.branch;
  assign ex_illegal    = ex_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage (bypass vectors only with
// ALU_ISSUE_WB_BYPASS_EN defined).
module tb_alu_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic        stall;
  logic        flush;
`ifdef ALU_ISSUE_WB_BYPASS_EN
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
`endif
  logic        ex_valid;
  logic [3:0]  ex_alu_ctrl;
  logic [31:0] ex_data1;
  logic [31:0] ex_data2;
  logic [4:0]  ex_shamt;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_dest;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_branch;
  logic        ex_illegal;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  alu_issue_stage #(.DW(32), .RW(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid      (id_valid),
    .id_instr      (id_instr),
    .id_rs_data    (id_rs_data),
    .id_rt_data    (id_rt_data),
    .stall         (stall),
    .flush         (flush),
`ifdef ALU_ISSUE_WB_BYPASS_EN
    .wb_we         (wb_we),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
`endif
    .ex_valid      (ex_valid),
    .ex_alu_ctrl   (ex_alu_ctrl),
    .ex_data1      (ex_data1),
    .ex_data2      (ex_data2),
    .ex_shamt      (ex_shamt),
    .ex_store_data (ex_store_data),
    .ex_dest       (ex_dest),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_branch     (ex_branch),
    .ex_illegal    (ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic check_ex(input string tag, input logic v, input logic [3:0] alu,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [4:0] sh,
                          input logic [31:0] st, input logic [4:0] dst, input logic rw,
                          input logic mr, input logic mw, input logic br, input logic il);
    check({tag, ".valid"}, 32'(ex_valid),     32'(v));
    check({tag, ".alu"},   32'(ex_alu_ctrl),  32'(alu));
    check({tag, ".d1"},    ex_data1,          d1);
    check({tag, ".d2"},    ex_data2,          d2);
    check({tag, ".shamt"}, 32'(ex_shamt),     32'(sh));
    check({tag, ".store"}, ex_store_data,     st);
    check({tag, ".dest"},  32'(ex_dest),      32'(dst));
    check({tag, ".rw"},    32'(ex_reg_write), 32'(rw));
    check({tag, ".mr"},    32'(ex_mem_read),  32'(mr));
    check({tag, ".mw"},    32'(ex_mem_write), 32'(mw));
    check({tag, ".br"},    32'(ex_branch),    32'(br));
    check({tag, ".ill"},   32'(ex_illegal),   32'(il));
  endtask

  task automatic check_bubble(input string tag);
    check_ex(tag, 1'b0, 4'b0001, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] rsd, input logic [31:0] rtd);
    id_valid   = 1'b1;
    id_instr   = instr;
    id_rs_data = rsd;
    id_rt_data = rtd;
    step();
  endtask

  initial begin
    rst_n = 1'b0; id_valid = 1'b0; id_instr = '0; id_rs_data = '0; id_rt_data = '0;
    stall = 1'b0; flush = 1'b0;
`ifdef ALU_ISSUE_WB_BYPASS_EN
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
`endif
    step(); step();
    check_bubble("reset");
    rst_n = 1'b1;
    step();
    check_bubble("idle");

    issue(rtype(1, 2, 3, 0, 6'h20), 32'd5, 32'd7);
    check_ex("add",  1, 4'h1, 32'd5, 32'd7, 0, 32'd7, 5'd3, 1, 0, 0, 0, 0);
    issue(itype(6'h08, 1, 4, 16'hFFFF), 32'd5, 32'd7);
    check_ex("addi", 1, 4'h1, 32'd5, 32'hFFFF_FFFF, 0, 32'd7, 5'd4, 1, 0, 0, 0, 0);
    issue(itype(6'h0C, 1, 4, 16'hFFFF), 32'd5, 32'd7);
    check_ex("andi", 1, 4'h4, 32'd5, 32'h0000_FFFF, 0, 32'd7, 5'd4, 1, 0, 0, 0, 0);
    issue(itype(6'h0D, 1, 5, 16'h8001), 32'h10, 32'h0);
    check_ex("ori",  1, 4'h5, 32'h10, 32'h0000_8001, 0, 32'h0, 5'd5, 1, 0, 0, 0, 0);
    issue(itype(6'h0E, 2, 6, 16'h00F0), 32'hFF, 32'h3);
    check_ex("xori", 1, 4'h6, 32'hFF, 32'hF0, 0, 32'h3, 5'd6, 1, 0, 0, 0, 0);
    issue(rtype(0, 1, 2, 4, 6'h00), 32'd5, 32'd9);
    check_ex("sll",  1, 4'h0, 32'd0, 32'd9, 5'd4, 32'd9, 5'd2, 1, 0, 0, 0, 0);
    issue(rtype(0, 2, 7, 31, 6'h02), 32'd1, 32'h8000_0000);
    check_ex("srl",  1, 4'hF, 32'd0, 32'h8000_0000, 5'd31, 32'h8000_0000, 5'd7, 1, 0, 0, 0, 0);
    issue(rtype(1, 2, 6, 0, 6'h23), 32'd10, 32'd3);
    check_ex("subu", 1, 4'h2, 32'd10, 32'd3, 0, 32'd3, 5'd6, 1, 0, 0, 0, 0);
    issue(rtype(1, 2, 8, 0, 6'h26), 32'hA, 32'h5);
    check_ex("xor",  1, 4'h6, 32'hA, 32'h5, 0, 32'h5, 5'd8, 1, 0, 0, 0, 0);
    issue(rtype(1, 2, 9, 0, 6'h2A), 32'd1, 32'd2);
    check_ex("slt",  1, 4'hA, 32'd1, 32'd2, 0, 32'd2, 5'd9, 1, 0, 0, 0, 0);
    issue(itype(6'h0A, 1, 8, 16'hFFFE), 32'd3, 32'd4);
    check_ex("slti", 1, 4'hA, 32'd3, 32'hFFFF_FFFE, 0, 32'd4, 5'd8, 1, 0, 0, 0, 0);
    issue(itype(6'h0F, 0, 0, 16'h1234), 32'd5, 32'd6);
    check_ex("lui0", 1, 4'h7, 32'd0, 32'h1234, 0, 32'd6, 5'd0, 0, 0, 0, 0, 0);
    issue(itype(6'h04, 1, 2, 16'h0010), 32'd5, 32'd5);
    check_ex("beq",  1, 4'h2, 32'd5, 32'd5, 0, 32'd5, 5'd2, 0, 0, 0, 1, 0);
    issue(itype(6'h2B, 1, 2, 16'h0008), 32'h100, 32'hAB);
    check_ex("sw",   1, 4'h1, 32'h100, 32'h8, 0, 32'hAB, 5'd2, 0, 0, 1, 0, 0);
    issue(rtype(1, 2, 0, 0, 6'h20), 32'd1, 32'd1);
    check_ex("rd0",  1, 4'h1, 32'd1, 32'd1, 0, 32'd1, 5'd0, 0, 0, 0, 0, 0);
    issue(itype(6'h3F, 1, 2, 16'h1234), 32'd5, 32'd6);
    check_ex("illop", 1, 4'h1, 32'd0, 32'd0, 0, 32'd0, 5'd0, 0, 0, 0, 0, 1);
    issue(rtype(1, 2, 3, 0, 6'h3F), 32'd5, 32'd6);
    check_ex("illfn", 1, 4'h1, 32'd0, 32'd0, 0, 32'd0, 5'd0, 0, 0, 0, 0, 1);

    // New ID inputs must not reach EX before the next edge
    id_instr = rtype(1, 2, 3, 0, 6'h20); id_rs_data = 32'h77;
    #2;
    check("nocomb.d1", ex_data1, 32'd0);

    issue(itype(6'h23, 1, 9, 16'hFFFC), 32'h100, 32'h33);
    check_ex("lw",     1, 4'h1, 32'h100, 32'hFFFF_FFFC, 0, 32'h33, 5'd9, 1, 1, 0, 0, 0);
    stall = 1'b1;
    issue(rtype(1, 2, 3, 0, 6'h22), 32'd1, 32'd2);
    check_ex("stall1", 1, 4'h1, 32'h100, 32'hFFFF_FFFC, 0, 32'h33, 5'd9, 1, 1, 0, 0, 0);
    step();
    check_ex("stall2", 1, 4'h1, 32'h100, 32'hFFFF_FFFC, 0, 32'h33, 5'd9, 1, 1, 0, 0, 0);
    flush = 1'b1;
    step();
    check_bubble("flush");
    flush = 1'b0; stall = 1'b0; id_valid = 1'b0;
    step();
    check_bubble("novalid");

    issue(itype(6'h23, 1, 9, 16'h0004), 32'h200, 32'h44);
    check_ex("lw2", 1, 4'h1, 32'h200, 32'h4, 0, 32'h44, 5'd9, 1, 1, 0, 0, 0);
    stall = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    check_bubble("rst_async");
    #1 rst_n = 1'b1;
    step();
    check_bubble("rst_hold");
    stall = 1'b0;

`ifdef ALU_ISSUE_WB_BYPASS_EN
    wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'h55;
    issue(rtype(1, 2, 3, 0, 6'h20), 32'd5, 32'd7);
    check_ex("byp_rs", 1, 4'h1, 32'h55, 32'd7, 0, 32'd7, 5'd3, 1, 0, 0, 0, 0);
    wb_addr = 5'd2;
    issue(rtype(1, 2, 3, 0, 6'h20), 32'd5, 32'd7);
    check_ex("byp_rt", 1, 4'h1, 32'd5, 32'h55, 0, 32'h55, 5'd3, 1, 0, 0, 0, 0);
    wb_addr = 5'd0;
    issue(rtype(0, 2, 3, 0, 6'h20), 32'd0, 32'd7);
    check_ex("byp_r0", 1, 4'h1, 32'd0, 32'd7, 0, 32'd7, 5'd3, 1, 0, 0, 0, 0);
    wb_addr = 5'd1; wb_we = 1'b0;
    issue(rtype(1, 2, 3, 0, 6'h20), 32'd5, 32'd7);
    check_ex("byp_off", 1, 4'h1, 32'd5, 32'd7, 0, 32'd7, 5'd3, 1, 0, 0, 0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
